pool_stream: RTL

// Parametrised streaming max-pool layer for the CNN pipeline; generalises the fixed 2-channel/1-channel pooling stages.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/pool_stream_if.sv | 28 ++
 rtl/pool_lane.sv | 52 +++++
 rtl/pool_stream.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Types and constants shared by the CNN pipeline layers (conv, pool, dense).
package cnn_pkg;

  localparam int DW_DEF   = 18;
  localparam int POOL_MIN = 2;
  localparam int POOL_MAX = 4;

  typedef logic signed [DW_DEF-1:0] fx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pool_state_t;

endpackage

// File: rtl/pool_stream_if.sv
// Streaming feature-map link between layers: frame control, pixel input and pooled output.
interface pool_stream_if
  import cnn_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CH = 2
);

  logic            strt;
  logic            tx_done;
  logic            din_vld;
  logic [CH*DW-1:0] din;
  logic            bsy;
  logic            dout_vld;
  logic [CH*DW-1:0] dout;
  logic            rdy;

  modport master (
    output strt, tx_done, din_vld, din,
    input  bsy, dout_vld, dout, rdy
  );

  modport slave (
    input  strt, tx_done, din_vld, din,
    output bsy, dout_vld, dout, rdy
  );

endinterface

// File: rtl/pool_lane.sv
// One pooling lane: per-window running-max buffer, signed compare and optional ReLU.
module pool_lane
  import cnn_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int W_OUT = 12,
  parameter int WW    = 4,
  parameter int RELU  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc,
  input  logic                 first,
  input  logic                 last,
  input  logic [WW-1:0]        win,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  // Read-modify-write every accepted pixel with one-cycle latency, so the read stays asynchronous.
  logic signed [DW-1:0] pmax [W_OUT];
  logic signed [DW-1:0] cur;
  logic signed [DW-1:0] mx;
  logic signed [DW-1:0] res;
  logic signed [DW-1:0] dout_reg;

  always_comb begin
    cur = pmax[win];
    mx  = (din > cur) ? din : cur;
    res = mx;
    if (RELU != 0 && mx[DW-1]) begin
      res = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pmax[win] <= first ? din : mx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (acc && last) begin
      dout_reg <= res;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/pool_stream.sv
// Streaming max-pool layer: shared frame FSM and raster counters driving CH pool_lane instances.
module pool_stream
  import cnn_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CH    = 2,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int POOL  = 2,
  parameter int RELU  = 0
) (
  input logic         clk,
  input logic         rst_n,
  pool_stream_if.slave bus
);

  localparam int W_OUT = IMG_W / POOL;
  localparam int H_OUT = IMG_H / POOL;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int PW    = $clog2(POOL);
  localparam int WW    = (W_OUT > 1) ? $clog2(W_OUT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(POOL - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(W_OUT - 1);

  generate
    if (POOL < POOL_MIN || POOL > POOL_MAX || POOL > IMG_W || POOL > IMG_H) begin : g_bad_cfg
      $error("pool_stream: POOL must be 2..4 and not exceed IMG_W / IMG_H");
    end
  endgenerate

  pool_state_t   state_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [PW-1:0] col_ph_reg;
  logic [PW-1:0] row_ph_reg;
  logic [WW-1:0] win_reg;
  logic          bsy_reg;
  logic          dout_vld_reg;
  logic          rdy_reg;

  logic col_end;
  logic row_end;
  logic col_keep;
  logic row_keep;
  logic first_px;
  logic last_px;
  logic accept;
  logic lane_acc;

  assign col_end  = (col_reg == COL_LAST);
  assign row_end  = (row_reg == ROW_LAST);
  // Remainder rows/columns beyond the last full window are consumed but never pooled.
  assign col_keep = (int'(col_reg) < W_OUT * POOL);
  assign row_keep = (int'(row_reg) < H_OUT * POOL);
  assign first_px = (row_ph_reg == '0) && (col_ph_reg == '0);
  assign last_px  = (row_ph_reg == PH_LAST) && (col_ph_reg == PH_LAST);
  assign accept   = (state_reg == RUN) && bus.din_vld && !bus.tx_done;
  assign lane_acc = accept && col_keep && row_keep;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      col_ph_reg   <= '0;
      row_ph_reg   <= '0;
      win_reg      <= '0;
      bsy_reg      <= 1'b0;
      dout_vld_reg <= 1'b0;
      rdy_reg      <= 1'b0;
    end else begin
      dout_vld_reg <= 1'b0;
      rdy_reg      <= 1'b0;
      if (bus.tx_done) begin
        state_reg  <= IDLE;
        bsy_reg    <= 1'b0;
        col_reg    <= '0;
        row_reg    <= '0;
        col_ph_reg <= '0;
        row_ph_reg <= '0;
        win_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.strt) begin
              state_reg <= RUN;
              bsy_reg   <= 1'b1;
            end
          end
          RUN: begin
            if (bus.din_vld) begin
              dout_vld_reg <= col_keep && row_keep && last_px;
              if (col_end) begin
                col_reg    <= '0;
                col_ph_reg <= '0;
                win_reg    <= '0;
                if (row_end) begin
                  row_reg    <= '0;
                  row_ph_reg <= '0;
                  state_reg  <= IDLE;
                  bsy_reg    <= 1'b0;
                  rdy_reg    <= 1'b1;
                end else begin
                  row_reg    <= row_reg + 1'b1;
                  row_ph_reg <= (row_ph_reg == PH_LAST) ? '0 : row_ph_reg + 1'b1;
                end
              end else begin
                col_reg <= col_reg + 1'b1;
                if (col_ph_reg == PH_LAST) begin
                  col_ph_reg <= '0;
                  // Window index saturates so remainder columns cannot run past the buffer.
                  if (win_reg != WIN_LAST) begin
                    win_reg <= win_reg + 1'b1;
                  end
                end else begin
                  col_ph_reg <= col_ph_reg + 1'b1;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  logic [CH*DW-1:0] dout_lanes;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      pool_lane #(
        .DW    (DW),
        .W_OUT (W_OUT),
        .WW    (WW),
        .RELU  (RELU)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (lane_acc),
        .first (first_px),
        .last  (last_px),
        .win   (win_reg),
        .din   (bus.din[gi*DW +: DW]),
        .dout  (dout_lanes[gi*DW +: DW])
      );
    end
  endgenerate

  assign bus.bsy      = bsy_reg;
  assign bus.dout_vld = dout_vld_reg;
  assign bus.rdy      = rdy_reg;
  assign bus.dout     = dout_lanes;

endmodule
